segment_display_scanner: RTL and testbench

- Parametrised multi-digit 7-segment driver that replaces the fixed single-purpose display/adder controller at the top level.
- Converts a binary register value to BCD sequentially (double-dabble) and time-multiplexes NUM_DIGITS common-anode digits.
- Debounces the user push-button and emits a one-cycle press pulse, intended for a processor-visible register.
- Sits between regfile tap outputs, board pins and button input.

---
 rtl/segment_display_scanner.sv | 186 ++++++++++++++++++
 tb/tb_segment_display_scanner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/segment_display_scanner.sv
// segment_display_scanner: double-dabble BCD converter, multiplexed 7-segment scan and push-button debouncer.
// Ports: clock/reset (sync, active-high); value = unsigned binary to show; blank_lz = blank leading zeros;
//   button = raw push-button; anode = active-low one-hot digit enables; segments = {g,f,e,d,c,b,a} active-low;
//   button_level/button_pulse = debounced level and one-cycle rising pulse; overflow = value too wide for the digits.
// Optional: define SEG_HEX_MODE_EN to add the hex_mode input (raw hexadecimal display, converter bypassed).
module segment_display_scanner #(
   parameter int NUM_DIGITS      = 8,
   parameter int DATA_WIDTH      = 27,
   parameter int REFRESH_DIV     = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] value,
   input  logic                  blank_lz,
`ifdef SEG_HEX_MODE_EN
   input  logic                  hex_mode,
`endif
   input  logic                  button,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [6:0]            segments,
   output logic                  button_level,
   output logic                  button_pulse,
   output logic                  overflow
);
   localparam int DIG_W = 4 * NUM_DIGITS;
   localparam int BCD_W = DIG_W + 4;
   localparam int RW    = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int CW    = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int IW    = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int NW    = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d, adj;
   logic [NW-1:0]           iter_q, iter_d;
   logic                    sat_q, sat_d, sat_bit;
   logic                    hex_q, hex_d, hex_req;
   logic [DIG_W-1:0]        disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [RW-1:0]           ref_q, ref_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              seg_q, seg_d;
   logic                    meta_q, sync_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    level_q, level_d, pulse_q, pulse_d;
   logic                    blank;
   logic [DIG_W+DATA_WIDTH-1:0] bin_ext;

`ifdef SEG_HEX_MODE_EN
   assign hex_req = hex_mode;
`else
   assign hex_req = 1'b0;
`endif

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: seg_of = 7'h40;
         4'h1: seg_of = 7'h79;
         4'h2: seg_of = 7'h24;
         4'h3: seg_of = 7'h30;
         4'h4: seg_of = 7'h19;
         4'h5: seg_of = 7'h12;
         4'h6: seg_of = 7'h02;
         4'h7: seg_of = 7'h78;
         4'h8: seg_of = 7'h00;
         4'h9: seg_of = 7'h10;
         4'hA: seg_of = 7'h08;
         4'hB: seg_of = 7'h03;
         4'hC: seg_of = 7'h46;
         4'hD: seg_of = 7'h21;
         4'hE: seg_of = 7'h06;
         default: seg_of = 7'h0E;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      sat_d   = sat_q;
      hex_d   = hex_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      for (int k = 0; k <= NUM_DIGITS; k++)
         adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
      // A bit leaving the spare top nibble means the value needs even more digits; remember it
      // so a value whose surviving top digit happens to be 0 still reports overflow.
      sat_bit = adj[BCD_W-1];
      bin_ext = {{DIG_W{1'b0}}, bin_q};
      case (state_q)
         IDLE: begin
            bin_d   = value;
            bcd_d   = '0;
            iter_d  = '0;
            sat_d   = 1'b0;
            hex_d   = hex_req;
            state_d = hex_req ? DONE : SHIFT;
         end
         SHIFT: begin
            {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
            sat_d   = sat_q | sat_bit;
            iter_d  = iter_q + 1'b1;
            state_d = iter_q == NW'(DATA_WIDTH - 1) ? DONE : SHIFT;
         end
         default: begin
            disp_d  = hex_q ? bin_ext[DIG_W-1:0] : bcd_q[DIG_W-1:0];
            ovf_d   = hex_q ? |bin_ext[DIG_W+DATA_WIDTH-1:DIG_W] : sat_q | (|bcd_q[BCD_W-1:DIG_W]);
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      ref_d   = ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + 1'b1;
      idx_d   = ref_q != RW'(REFRESH_DIV - 1) ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      anode_d = ~(NUM_DIGITS'(1) << idx_d);
      // Blank when this digit and everything above it are zero; digit 0 always shows.
      blank   = blank_lz & ~ovf_q & (idx_d != '0) & ((disp_q >> {idx_d, 2'b00}) == '0);
      seg_d   = ovf_q ? 7'h3F : blank ? 7'h7F : seg_of(disp_q[4*idx_d +: 4]);
   end

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      pulse_d = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync_q;
            pulse_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         sat_q   <= 1'b0;
         hex_q   <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         ref_q   <= '0;
         idx_q   <= '0;
         anode_q <= '1;
         seg_q   <= 7'h7F;
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         sat_q   <= sat_d;
         hex_q   <= hex_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         meta_q  <= button;
         sync_q  <= meta_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign anode        = anode_q;
   assign segments     = seg_q;
   assign button_level = level_q;
   assign button_pulse = pulse_q;
   assign overflow     = ovf_q;
endmodule

// File: tb/tb_segment_display_scanner.sv
// tb_segment_display_scanner: randomized and directed checks of the scanner against an arithmetic display model.
module tb_segment_display_scanner;
   localparam int ND = 4;
   localparam int DW = 16;
   localparam int RD = 4;
   localparam int DB = 8;
   localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] value;
   logic          blank_lz;
   logic          hex_mode;
   logic          button;
   logic [ND-1:0] anode;
   logic [6:0]    segments;
   logic          button_level;
   logic          button_pulse;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int unsigned cur_v;
   bit cur_blz, cur_hex;

   segment_display_scanner #(
      .NUM_DIGITS(ND), .DATA_WIDTH(DW), .REFRESH_DIV(RD), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .value(value),
      .blank_lz(blank_lz),
`ifdef SEG_HEX_MODE_EN
      .hex_mode(hex_mode),
`endif
      .button(button),
      .anode(anode),
      .segments(segments),
      .button_level(button_level),
      .button_pulse(button_pulse),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc       <= reset ? 0 : cyc + 1;
      pulse_cnt <= pulse_cnt + int'(button_pulse);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit exp_ovf(input int unsigned v, input bit hx);
      return hx ? (v >> (4 * ND)) != 0 : v > 9999;
   endfunction

   function automatic logic [6:0] exp_seg(input int unsigned v, input bit blz, input bit hx, input int i);
      int unsigned base = hx ? 16 : 10;
      int unsigned p = 1;
      for (int j = 0; j < i; j++) p *= base;
      if (exp_ovf(v, hx)) return 7'h3F;
      if (blz && i > 0 && v < p) return 7'h7F;
      return SEG_TAB[(v / p) % base];
   endfunction

   task automatic scan_check(input string tag);
      for (int n = 0; n < 4 * RD; n++) begin
         int idx;
         logic [ND-1:0] ea;
         @(negedge clock);
         idx = (cyc / RD) % ND;
         ea = ~(ND'(1) << idx);
         check({tag, "_anode"}, 32'(anode), 32'(ea));
         check({tag, "_seg"}, 32'(segments), 32'(exp_seg(cur_v, cur_blz, cur_hex, idx)));
      end
   endtask

   task automatic apply(input int unsigned v, input bit blz, input bit hx, input string tag);
      @(negedge clock);
      value = DW'(v);
      blank_lz = blz;
      hex_mode = hx;
      cur_v = v;
      cur_blz = blz;
      cur_hex = hx;
      repeat (40) @(negedge clock);
      check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf(v, hx)));
      scan_check(tag);
   endtask

   initial begin
      reset = 1'b1;
      value = '0;
      blank_lz = 1'b0;
      hex_mode = 1'b0;
      button = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_anode", 32'(anode), 32'hF);
      check("rst_seg", 32'(segments), 32'h7F);
      check("rst_level", 32'(button_level), 0);
      check("rst_pulse", 32'(button_pulse), 0);
      check("rst_ovf", 32'(overflow), 0);
      reset = 1'b0;

      apply(1234, 0, 0, "v1234");
      apply(7, 1, 0, "v7_blz");
      apply(0, 1, 0, "v0_blz");
      apply(9999, 0, 0, "v9999");
      apply(10000, 1, 0, "v10000");
      apply(65535, 0, 0, "vmax");
      apply(100, 1, 0, "v100_blz");
      for (int r = 0; r < 12; r++) begin
         int unsigned v;
         v = $urandom_range(0, 3) == 0 ? $urandom_range(0, 65535) : $urandom_range(0, 9999) >> $urandom_range(0, 13);
         apply(v, 1'($urandom_range(0, 1)), 0, "rand");
      end

      apply(54321, 0, 0, "v54321");
      @(negedge clock);
      value = 16'd4321;
      cur_v = 4321;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_anode", 32'(anode), 32'hF);
      check("midrst_seg", 32'(segments), 32'h7F);
      check("midrst_ovf", 32'(overflow), 0);
      reset = 1'b0;
      repeat (36) @(negedge clock);
      check("post_rst_ovf", 32'(overflow), 0);
      scan_check("post_rst");

      for (int i = 0; i < 30; i++) begin
         button = 1'((i / 3) & 1);
         @(negedge clock);
         check("bounce_level", 32'(button_level), 0);
      end
      check("bounce_pulses", 32'(pulse_cnt), 0);
      button = 1'b1;
      for (int i = 0; i < 15 && pulse_cnt == 0; i++) @(negedge clock);
      check("press_pulse_seen", 32'(pulse_cnt), 1);
      repeat (20) @(negedge clock);
      check("press_level", 32'(button_level), 1);
      check("press_one_pulse", 32'(pulse_cnt), 1);
      button = 1'b0;
      repeat (20) @(negedge clock);
      check("release_level", 32'(button_level), 0);
      check("release_no_pulse", 32'(pulse_cnt), 1);

`ifdef SEG_HEX_MODE_EN
      apply(32'hBEEF, 0, 1, "hex_beef");
      apply(32'h00A0, 1, 1, "hex_a0_blz");
      apply(32'(9999), 0, 0, "back_to_bcd");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
